// File: rtl/frame_reader.sv
// Frame reader: pops an upstream frame FIFO, checks SOF/EOF framing and length,
// and streams retained bytes through a 4-entry output buffer with valid/ready.
module frame_reader #(
  parameter int MAX_FRAME_LEN = 1024,
  parameter int LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_sof,
  input  logic             fifo_eof,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LEN_W-1:0] out_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_orphan,
  output logic             err_trunc,
  output logic             err_oversize,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_e;

  typedef struct packed {
    logic [7:0]       data;
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] len;
  } beat_t;

  localparam logic [LEN_W:0] MaxLen = (LEN_W + 1)'(MAX_FRAME_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             inflight_q;
  beat_t            buf_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       occ_q;
  logic [15:0]      fc_q;

  logic             push, pop;
  beat_t            push_beat, head;
  logic [LEN_W:0]   len_inc;
  logic             too_long;
  logic [2:0]       occ_plus;

  assign len_inc  = {1'b0, len_q} + 1'b1;
  assign too_long = len_inc > MaxLen;
  assign occ_plus = occ_q + {2'b0, inflight_q};

  // Gated by reset so no pop is requested while the block is held in reset.
  assign fifo_rd_en = reset && !fifo_empty && (occ_plus <= 3'd2);

  assign head      = buf_q[rd_ptr_q];
  assign out_valid = (occ_q != 3'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_sof   = out_valid && head.sof;
  assign out_eof   = out_valid && head.eof;
  assign out_len   = out_valid ? head.len : '0;
  assign frame_count = fc_q;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      inflight_q <= fifo_rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (inflight_q) begin
      if (fifo_sof) begin
        len_d   = LEN_W'(1);
        state_d = fifo_eof ? IDLE : IN_FRAME;
      end else begin
        unique case (state_q)
          IDLE: ;
          IN_FRAME: begin
            if (too_long) begin
              state_d = DROP;
            end else begin
              len_d = len_inc[LEN_W-1:0];
              if (fifo_eof) state_d = IDLE;
            end
          end
          DROP:    if (fifo_eof) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    push         = 1'b0;
    push_beat    = '0;
    err_orphan   = 1'b0;
    err_trunc    = 1'b0;
    err_oversize = 1'b0;
    if (inflight_q) begin
      if (fifo_sof) begin
        push           = 1'b1;
        push_beat.data = fifo_dout;
        push_beat.sof  = 1'b1;
        push_beat.eof  = fifo_eof;
        push_beat.len  = fifo_eof ? LEN_W'(1) : '0;
        err_trunc      = (state_q == IN_FRAME);
      end else begin
        unique case (state_q)
          IDLE: err_orphan = 1'b1;
          IN_FRAME: begin
            if (too_long) begin
              err_oversize = 1'b1;
            end else begin
              push           = 1'b1;
              push_beat.data = fifo_dout;
              push_beat.eof  = fifo_eof;
              push_beat.len  = fifo_eof ? len_inc[LEN_W-1:0] : '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      fc_q     <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= push_beat;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      occ_q <= occ_q + {2'b0, push} - {2'b0, pop};
      if (pop && head.eof && (fc_q != '1)) fc_q <= fc_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: an upstream FIFO model feeds bytes, a framing
// reference model queues expected beats, and a monitor compares popped beats.
module tb_frame_reader;

  localparam int MAXL = 16;
  localparam int LW   = $clog2(MAXL + 1);

  logic          rd_clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [7:0]    fifo_dout = '0;
  logic          fifo_sof = 1'b0;
  logic          fifo_eof = 1'b0;
  logic [7:0]    out_data;
  logic          out_sof, out_eof, out_valid;
  logic [LW-1:0] out_len;
  logic          out_ready = 1'b0;
  logic          err_orphan, err_trunc, err_oversize;
  logic [15:0]   frame_count;

  frame_reader #(.MAX_FRAME_LEN(MAXL), .LEN_W(LW)) dut (
    .rd_clk(rd_clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .out_len(out_len),
    .out_valid(out_valid), .out_ready(out_ready), .err_orphan(err_orphan),
    .err_trunc(err_trunc), .err_oversize(err_oversize), .frame_count(frame_count)
  );

  always #5 rd_clk = ~rd_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic [7:0] d; logic s; logic e;} fbyte_t;

  fbyte_t      fq[$];
  logic [31:0] expq[$];
  int          hs_cyc[$];
  bit          will_pop = 0;
  bit          ready_toggle = 0;
  bit          ready_lvl = 0;
  bit          occ_watch = 0;
  int          cyc = 0;
  int          first_pop_cyc = -1;
  int          first_valid_cyc = -1;

  int mstate = 0;
  int mlen = 0;
  int exp_orph = 0, exp_trunc = 0, exp_over = 0, exp_fc = 0;
  int obs_orph = 0, obs_trunc = 0, obs_over = 0;

  always @(posedge rd_clk) cyc++;

  function automatic logic [31:0] beat(input logic [7:0] d, input logic s, input logic e, input int len);
    logic [LW-1:0] l;
    l = LW'(len);
    return {17'b0, d, s, e, l};
  endfunction

  // Reference framing model, run as each byte is queued for the upstream FIFO.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    fq.push_back({d, s, e});
    if (s) begin
      if (mstate == 1) exp_trunc++;
      expq.push_back(beat(d, 1'b1, e, e ? 1 : 0));
      mlen   = 1;
      mstate = e ? 0 : 1;
    end else begin
      case (mstate)
        0: exp_orph++;
        1: begin
          if (mlen + 1 > MAXL) begin
            exp_over++;
            mstate = 2;
          end else begin
            mlen++;
            expq.push_back(beat(d, 1'b0, e, e ? mlen : 0));
            if (e) mstate = 0;
          end
        end
        default: if (e) mstate = 0;
      endcase
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + 8'(i), i == 0, i == n - 1);
  endtask

  // Upstream FIFO: byte appears the cycle after an accepted pop, junk otherwise.
  initial forever begin
    fbyte_t b;
    @(negedge rd_clk);
    if (will_pop) begin
      b = fq.pop_front();
      fifo_dout = b.d;
      fifo_sof  = b.s;
      fifo_eof  = b.e;
    end else begin
      fifo_dout = 8'($urandom);
      fifo_sof  = 1'($urandom);
      fifo_eof  = 1'($urandom);
    end
    will_pop   = 0;
    fifo_empty = (fq.size() == 0);
    #1;
    out_ready = ready_toggle ? ~out_ready : ready_lvl;
    #3;
    if (fifo_rd_en && !fifo_empty) begin
      will_pop = 1;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
  end

  initial begin : monitor
    logic [31:0] vec, prev_vec, e;
    bit          prev_stall;
    prev_stall = 0;
    prev_vec   = '0;
    forever begin
      @(negedge rd_clk);
      #2;
      if (!reset) begin
        prev_stall = 0;
      end else begin
        if (err_orphan)   obs_orph++;
        if (err_trunc)    obs_trunc++;
        if (err_oversize) obs_over++;
        vec = {17'b0, out_data, out_sof, out_eof, out_len};
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall) chk("stall_hold", vec, prev_vec);
        if (out_valid && out_ready) begin
          hs_cyc.push_back(cyc);
          if (expq.size() == 0) begin
            chk("beat_unexpected", vec, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk("beat", vec, e);
            if (e[LW] && exp_fc < 65535) exp_fc++;
          end
        end
        if (occ_watch) chk("occ_le4", {31'b0, dut.occ_q <= 3'd4}, 1);
        prev_stall = out_valid && !out_ready;
        prev_vec   = vec;
      end
    end
  end

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge rd_clk);
      #3;
      done = (fq.size() == 0) && !fifo_rd_en && !dut.inflight_q && (expq.size() == 0) && !out_valid;
    end
    chk({tag, "_drain"}, {31'b0, done}, 1);
  endtask

  task automatic counts(input string tag);
    chk({tag, "_fcount"}, frame_count, exp_fc);
    chk({tag, "_orphan"}, obs_orph, exp_orph);
    chk({tag, "_trunc"}, obs_trunc, exp_trunc);
    chk({tag, "_oversize"}, obs_over, exp_over);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_data_flags_len"}, {17'b0, out_data, out_sof, out_eof, out_len}, 0);
    chk({tag, "_errs"}, {29'b0, err_orphan, err_trunc, err_oversize}, 0);
    chk({tag, "_rd_en"}, {31'b0, fifo_rd_en}, 0);
    chk({tag, "_fcount"}, frame_count, 0);
  endtask

  initial begin
    int o0;
    ready_lvl = 1;
    send_frame(8'hA0, 4);
    repeat (3) @(negedge rd_clk);
    #3;
    chk_zero_outputs("reset");

    reset = 1;
    #1;
    chk("rd_en_first_edge", {31'b0, fifo_rd_en}, 1);
    drain("s1");
    chk("s1_latency", first_valid_cyc - first_pop_cyc, 2);
    chk("s1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) chk("s1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    chk("s1_fc_one", frame_count, 1);
    counts("s1");

    o0 = obs_orph;
    send(8'h55, 1'b0, 1'b0);
    send_frame(8'hB0, 2);
    drain("s2");
    chk("s2_one_orphan", obs_orph - o0, 1);
    counts("s2");

    send(8'h10, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h21, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    drain("s3");
    counts("s3");

    send_frame(8'h40, MAXL + 4);
    send_frame(8'h80, 2);
    drain("s4");
    counts("s4");

    ready_toggle = 1;
    occ_watch    = 1;
    send_frame(8'hC0, MAXL);
    send_frame(8'hE0, 3);
    drain("s5");
    occ_watch    = 0;
    ready_toggle = 0;
    counts("s5");

    ready_lvl = 0;
    send(8'hD0, 1'b1, 1'b0);
    send(8'hD1, 1'b0, 1'b0);
    send(8'hD2, 1'b0, 1'b0);
    repeat (10) @(negedge rd_clk);
    #3;
    chk("s6_held_valid", {31'b0, out_valid}, 1);
    reset = 0;
    #1;
    chk_zero_outputs("s6_reset");
    expq.delete();
    mstate = 0;
    mlen   = 0;
    exp_fc = 0;
    o0     = obs_orph;
    send(8'hD3, 1'b0, 1'b0);
    send(8'hD4, 1'b0, 1'b0);
    send(8'hD5, 1'b0, 1'b1);
    repeat (2) @(negedge rd_clk);
    #3;
    reset     = 1;
    ready_lvl = 1;
    #1;
    chk("s6_rd_en_release", {31'b0, fifo_rd_en}, 1);
    send_frame(8'hF0, 3);
    drain("s6");
    chk("s6_three_orphans", obs_orph - o0, 3);
    counts("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 1024, largest legal frame in bytes, counting the SOF and EOF bytes.
REQ-002 Parameter LEN_W, default $clog2(MAX_FRAME_LEN+1), width of length outputs.
REQ-003 Port rd_clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset; the block is in reset while reset is 0.
REQ-005 Port fifo_empty, input, 1, gated empty from the upstream frame FIFO.
REQ-006 Port fifo_rd_en, output, 1, pop request to the upstream frame FIFO.
REQ-007 Port fifo_dout, input, 8, FIFO byte, valid on the cycle after an accepted pop.
REQ-008 Port fifo_sof, input, 1, start-of-frame flag, aligned with fifo_dout.
REQ-009 Port fifo_eof, input, 1, end-of-frame flag, aligned with fifo_dout.
REQ-010 Port out_data, output, 8, output stream byte.
REQ-011 Port out_sof, output, 1, first byte of frame.
REQ-012 Port out_eof, output, 1, last byte of frame.
REQ-013 Port out_len, output, LEN_W, frame byte count; valid only on the out_eof beat, 0 otherwise.
REQ-014 Port out_valid, output, 1, output beat present.
REQ-015 Port out_ready, input, 1, downstream accepts beat.
REQ-016 Port err_orphan, output, 1, one-cycle pulse when a byte arrives outside a frame.
REQ-017 Port err_trunc, output, 1, one-cycle pulse when SOF arrives inside an open frame.
REQ-018 Port err_oversize, output, 1, one-cycle pulse when a frame exceeds MAX_FRAME_LEN.
REQ-019 Port frame_count, output, 16, count of frames completed on output; saturates at 0xFFFF.

Function
REQ-020 FIFO read: fifo_rd_en = !fifo_empty && (buf_occ + inflight) <= 2; inflight is 1 on the cycle after fifo_rd_en was 1.
REQ-021 The arriving byte is classified on the cycle it arrives (one cycle after the pop); retained bytes are written into a 4-entry output buffer holding {data, sof, eof, len}.
REQ-022 The output buffer is first-in first-out; the head drives out_*; a beat pops when out_valid && out_ready; out_valid = (buf_occ != 0).
REQ-023 The output buffer supports a push and a pop in the same cycle; it never overflows under the REQ-020 rule.
REQ-024 The output stays stable (data/flags held) while out_valid && !out_ready.
REQ-025 FSM state IDLE: an arriving byte with sof=1 is retained with len_cnt=1 and moves to IN_FRAME, or to IDLE if eof=1 also (single-byte frame, out_len=1).
REQ-026 FSM state IDLE: an arriving byte with sof=0 is discarded, err_orphan pulses, and the FSM stays in IDLE.
REQ-027 FSM state IN_FRAME: a byte with sof=0 is retained and len_cnt increments; if eof=1, out_len=len_cnt+1 is stored and the FSM goes to IDLE.
REQ-028 FSM state IN_FRAME: a byte with sof=1 pulses err_trunc; the open frame is abandoned without an EOF, and the byte is handled as a new SOF per REQ-025.
REQ-029 FSM state IN_FRAME: if a retained byte would make len_cnt exceed MAX_FRAME_LEN, the byte is discarded, err_oversize pulses, and the FSM goes to DROP.
REQ-030 FSM state DROP: every byte is discarded until eof=1, then the FSM goes to IDLE; a byte with sof=1 in DROP starts a new frame per REQ-025, with no error pulse.
REQ-031 Simultaneous sof=1 and eof=1 inside IN_FRAME is handled as REQ-028 followed by the single-byte case.
REQ-032 frame_count increments on each popped beat with out_eof=1.
REQ-033 Latency: FIFO byte to out_valid is 2 cycles when the buffer is empty.
REQ-034 Throughput: 1 byte/cycle is sustained with out_ready=1.

Reset
REQ-035 While reset=0, all outputs are 0, buf_occ=0, inflight=0, len_cnt=0, FSM=IDLE, and frame_count=0.
REQ-036 Reset asserted mid-frame discards the buffered bytes and any in-flight byte; after release, the first retained byte is the next SOF.
REQ-037 The first pop is allowed on the first rising edge after reset deasserts.

Verification
REQ-038 Scenario: 4-byte frame A0..A3 (SOF on A0, EOF on A3), out_ready=1 -> A0..A3 on 4 consecutive cycles, out_sof on A0, out_eof+out_len=4 on A3, frame_count=1.
REQ-039 Scenario: orphan byte 0x55, then 2-byte frame -> one err_orphan pulse, 0x55 never output, frame output intact.
REQ-040 Scenario: SOF,B1,SOF,C1,EOF -> err_trunc pulse; output SOF,B1 (no EOF), then C-frame with out_len=3.
REQ-041 Scenario: MAX_FRAME_LEN=8, 12-byte frame, then a 2-byte frame -> 8 bytes out with no EOF, err_oversize once, remaining 4 dropped, next frame out_len=2.
REQ-042 Scenario: out_ready toggled 1/0 every cycle during a 16-byte frame -> no loss or duplication, fifo_rd_en never raises buf_occ above 4, and output held stable while stalled.
REQ-043 Scenario: reset=0 pulse after byte 3 of a 6-byte frame -> all outputs 0 immediately; the remaining bytes after release are orphans (err_orphan per byte) until the next SOF.
